// File: rtl/logic_function_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_lut_pkg
// Brief    : Shared state encoding and default truth table for the LUT block.
// Revision : 1.0 - initial release
// ============================================================================
package logic_lut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default function: minterms 2, 4, 7, 11, 12 of a 4-input function.
    localparam logic [15:0] C_INIT_DEFAULT = 16'h1894;

endpackage
`default_nettype wire

// File: rtl/logic_function_lut_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_function_lut_if
// Brief    : Evaluation request / result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_function_lut_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic [N_IN-1:0] in_vec;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [N_IN-1:0] out_vec;
    logic            out_f;

    // master: stimulus / consumer side
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_f
    );

    // slave: the LUT itself
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_f
    );
endinterface
`default_nettype wire

// File: rtl/logic_function_lut_tt_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tt_shift_reg
// Brief    : Serially loadable truth-table register with a read mux.
// Revision : 1.0 - initial release
// ============================================================================
module tt_shift_reg
    import logic_lut_pkg::*;
#(
    parameter int              TT_W = 16,
    parameter logic [TT_W-1:0] INIT = C_INIT_DEFAULT
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      shift_en,
    input  wire logic                      shift_bit,
    input  wire logic [$clog2(TT_W)-1:0]   rd_idx,
    output logic                           rd_bit
);

    logic [TT_W-1:0] r_tt;

    // Bits enter at the bottom, so the first bit shifted lands at TT_W-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tt <= INIT;
        end else if (shift_en) begin
            r_tt <= {r_tt[TT_W-2:0], shift_bit};
        end
    end

    assign rd_bit = r_tt[rd_idx];

endmodule
`default_nettype wire

// File: rtl/logic_function_lut.sv
`default_nettype none
// ============================================================================
// Module   : logic_function_lut
// Brief    : N-input LUT with valid/ready evaluation and exhaustive sweep.
// Revision : 1.0 - initial release
// ============================================================================
module logic_function_lut
    import logic_lut_pkg::*;
#(
    parameter int                 N_IN = 4,
    parameter logic [2**N_IN-1:0] INIT = C_INIT_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          load_en,
    input  wire logic          load_bit,
    input  wire logic          sweep_start,
    output logic               sweep_busy,
    output logic               sweep_done,
    output logic [N_IN:0]      ones_count,
    logic_function_lut_if.slave bus
);

    localparam int              TT_W       = 2**N_IN;
    localparam logic [N_IN-1:0] c_idx_last = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   w_idx_nxt;
    logic [N_IN:0]     r_cnt;
    logic [N_IN:0]     w_cnt_nxt;
    logic [N_IN:0]     r_ones;
    logic [N_IN:0]     w_ones_nxt;
    logic              r_out_valid;
    logic              r_out_f;
    logic [N_IN-1:0]   r_out_vec;
    logic              r_sweep_done;

    logic              w_slot_free;
    logic              w_in_ready;
    logic              w_res_load;
    logic [N_IN-1:0]   w_res_vec;
    logic [N_IN-1:0]   w_rd_idx;
    logic              w_rd_bit;
    logic              w_shift_en;
    logic              w_done_set;

    tt_shift_reg #(
        .TT_W (TT_W),
        .INIT (INIT)
    ) u_tt (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (w_shift_en),
        .shift_bit (load_bit),
        .rd_idx    (w_rd_idx),
        .rd_bit    (w_rd_bit)
    );

    assign w_slot_free = !r_out_valid || bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_ones_nxt  = r_ones;
        w_in_ready  = 1'b0;
        w_res_load  = 1'b0;
        w_res_vec   = bus.in_vec;
        w_rd_idx    = bus.in_vec;
        w_shift_en  = 1'b0;
        w_done_set  = 1'b0;

        case (r_state)
            IDLE: begin
                w_in_ready = w_slot_free && !sweep_start;
                w_shift_en = load_en;
                // A start request takes priority over a pending evaluation.
                if (sweep_start) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (bus.in_valid && w_in_ready) begin
                    w_res_load = 1'b1;
                    w_res_vec  = bus.in_vec;
                end
            end
            SWEEP: begin
                w_rd_idx = r_idx;
                if (w_slot_free) begin
                    w_res_load = 1'b1;
                    w_res_vec  = r_idx;
                    w_cnt_nxt  = r_cnt + {{N_IN{1'b0}}, w_rd_bit};
                    if (r_idx == c_idx_last) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            DONE: begin
                // Wait for the last pair to be taken before reporting.
                if (w_slot_free) begin
                    w_ones_nxt  = r_cnt;
                    w_done_set  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_ones       <= '0;
            r_sweep_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ones       <= w_ones_nxt;
            r_sweep_done <= w_done_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_f     <= 1'b0;
        end else if (w_res_load) begin
            r_out_valid <= 1'b1;
            r_out_vec   <= w_res_vec;
            r_out_f     <= w_rd_bit;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_vec   = r_out_vec;
    assign bus.out_f     = r_out_f;
    assign sweep_busy    = (r_state != IDLE);
    assign sweep_done    = r_sweep_done;
    assign ones_count    = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_logic_function_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_function_lut
// Brief    : Directed + random self-checking bench for logic_function_lut.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_function_lut;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_en;
    logic       load_bit;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [4:0] ones_count;

    int n_err = 0;
    int n_chk = 0;
    int mt[16];

    logic_function_lut_if #(.N_IN(4)) bus ();

    logic_function_lut #(.N_IN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_bit    (load_bit),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .ones_count  (ones_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++)
            mt[i] = (i == 2 || i == 4 || i == 7 || i == 11 || i == 12) ? 1 : 0;
    endfunction

    // A newly loaded bit becomes f(0); every earlier bit moves up one minterm.
    function automatic void model_shift(input int b);
        for (int i = 15; i > 0; i--) mt[i] = mt[i-1];
        mt[0] = b;
    endfunction

    function automatic int model_ones();
        int s = 0;
        for (int i = 0; i < 16; i++) s += mt[i];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            load_en  = 1'b1;
            load_bit = w[i];
            model_shift(int'(w[i]));
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input int stall_idx, input bit pulse_load,
                             input int exp_ones);
        int  seen    = 0;
        int  cyc     = 0;
        bit  got     = 1'b0;
        bit  stalled = 1'b0;
        sweep_start  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_vec   = 4'($urandom);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_start_inrdy"}, bus.in_ready, 0);
        tick();
        sweep_start  = 1'b0;
        bus.in_valid = 1'b0;
        chk({tag, "_busy0"}, sweep_busy, 1);
        while (!got && cyc < 100) begin
            load_en = 1'b0;
            if (pulse_load && bus.out_valid && bus.out_vec < 4'd14) begin
                load_en  = 1'($urandom_range(0, 1));
                load_bit = 1'($urandom_range(0, 1));
            end
            if (stall_idx >= 0 && !stalled && bus.out_valid && int'(bus.out_vec) == stall_idx) begin
                stalled       = 1'b1;
                load_en       = 1'b0;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    cyc++;
                    chk({tag, "_stall_valid"}, bus.out_valid, 1);
                    chk({tag, "_stall_vec"}, bus.out_vec, stall_idx);
                end
                bus.out_ready = 1'b1;
            end
            if (stall_idx < 0 && cyc >= 1 && cyc <= 16) begin
                chk({tag, "_t_valid"}, bus.out_valid, 1);
                chk({tag, "_t_vec"}, bus.out_vec, cyc - 1);
                chk({tag, "_t_busy"}, sweep_busy, 1);
                chk({tag, "_t_done"}, sweep_done, 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_pair_vec"}, bus.out_vec, seen);
                chk({tag, "_pair_f"}, bus.out_f, mt[seen % 16]);
                seen++;
            end
            tick();
            cyc++;
            if (sweep_done) got = 1'b1;
        end
        load_en = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        if (stall_idx < 0) chk({tag, "_done_cycle"}, cyc, 17);
        chk({tag, "_pairs"}, seen, 16);
        chk({tag, "_ones"}, ones_count, exp_ones);
        chk({tag, "_busy_end"}, sweep_busy, 0);
        tick();
        chk({tag, "_done_pulse"}, sweep_done, 0);
    endtask

    initial begin
        int  iv, v, ordy, le, lb;
        bit  exp_valid;
        int  exp_vec, exp_f;
        bit  found;

        model_reset();
        rst_n = 1'b0;
        load_en = 1'b0;
        load_bit = 1'b0;
        sweep_start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_f", bus.out_f, 0);
        chk("rst_out_vec", bus.out_vec, 0);
        chk("rst_busy", sweep_busy, 0);
        chk("rst_done", sweep_done, 0);
        chk("rst_ones", ones_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back evaluation of every vector against the reset table.
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = 4'(i);
            @(negedge clk);
            chk("eval_inrdy", bus.in_ready, 1);
            tick();
            chk("eval_valid", bus.out_valid, 1);
            chk("eval_vec", bus.out_vec, i);
            chk("eval_f", bus.out_f, mt[i]);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("eval_drain", bus.out_valid, 0);

        run_sweep("sw_def", -1, 1'b0, 5);
        load_word(16'hFFFF);
        run_sweep("sw_ones", -1, 1'b0, 16);
        load_word(16'h0000);
        run_sweep("sw_zero", -1, 1'b0, 0);
        load_word(16'($urandom));
        run_sweep("sw_stall", 6, 1'b1, model_ones());

        // Random evaluation with backpressure and concurrent table loads.
        exp_valid = 1'b0;
        exp_vec = 0;
        exp_f = 0;
        chk("rnd_start_valid", bus.out_valid, 0);
        for (int n = 0; n < 80; n++) begin
            iv   = int'($urandom_range(0, 1));
            v    = int'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0) ? 1 : 0;
            le   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            lb   = int'($urandom_range(0, 1));
            bus.in_valid  = 1'(iv);
            bus.in_vec    = 4'(v);
            bus.out_ready = 1'(ordy);
            load_en       = 1'(le);
            load_bit      = 1'(lb);
            @(negedge clk);
            chk("rnd_inrdy", bus.in_ready, (!exp_valid || ordy != 0) ? 1 : 0);
            if (iv != 0 && (!exp_valid || ordy != 0)) begin
                exp_valid = 1'b1;
                exp_vec   = v;
                exp_f     = mt[v];
            end else if (ordy != 0) begin
                exp_valid = 1'b0;
            end
            if (le != 0) model_shift(lb);
            tick();
            chk("rnd_valid", bus.out_valid, exp_valid);
            if (exp_valid) begin
                chk("rnd_vec", bus.out_vec, exp_vec);
                chk("rnd_f", bus.out_f, exp_f);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        load_en       = 1'b0;
        tick();

        // Reset asserted in the middle of a sweep.
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (bus.out_valid && bus.out_vec == 4'd9) found = 1'b1;
            else tick();
        end
        chk("mid_found9", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_vec", bus.out_vec, 0);
        chk("mid_rst_f", bus.out_f, 0);
        chk("mid_rst_busy", sweep_busy, 0);
        chk("mid_rst_ones", ones_count, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_rst_done", sweep_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        chk("mid_post_done", sweep_done, 0);
        chk("mid_post_busy", sweep_busy, 0);
        run_sweep("sw_after_rst", -1, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_function_lut.md
# logic_function_lut

Parametrised, clocked successor to the team's fixed gate-level 4-input logic function. It stores an N-input truth table in a register that is loadable serially at run time. It evaluates input vectors through a valid/ready output register. An on-chip sweep engine walks all 2^N input combinations, streams every (vector, result) pair and reports the minterm count, which replaces hand-written exhaustive truth-table benches. It sits between stimulus logic (switches, test sequencer) and display/checker logic.

## Interface
- N_IN, 4, number of function inputs (2..8)
- INIT, 16'h1894, reset truth table, 2^N_IN bits; bit i = f(i); default = minterms 2,4,7,11,12
- TT_W (localparam) = 2^N_IN
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- load_en  in  1  shift one truth-table bit this cycle
- load_bit  in  1  serial truth-table bit, minterm TT_W-1 first, minterm 0 last
- in_valid  in  1  evaluation request
- in_vec  in  N_IN  input vector, MSB = first variable (a)
- in_ready  out  1  request accepted when in_valid && in_ready
- out_valid  out  1  result register holds data
- out_ready  in  1  consumer accepts result
- out_vec  out  N_IN  vector the result belongs to
- out_f  out  1  f(out_vec)
- sweep_start  in  1  start exhaustive sweep
- sweep_busy  out  1  high in SWEEP or DONE
- sweep_done  out  1  one-cycle pulse at sweep end
- ones_count  out  N_IN+1  number of minterms found by the last completed sweep

## Operation
- States: IDLE, SWEEP, DONE.
- slot_free = !out_valid || out_ready.
- IDLE:
  - in_ready = slot_free && !sweep_start.
  - On accept: out_vec <= in_vec, out_f <= tt[in_vec], out_valid <= 1.
  - load_en: tt <= {tt[TT_W-2:0], load_bit}.
  - Load and accept in the same cycle: the evaluation uses the pre-shift table.
- sweep_start in IDLE: idx <= 0, cnt <= 0, go to SWEEP. It wins over a simultaneous in_valid, which is not accepted.
- SWEEP:
  - in_ready = 0. load_en and sweep_start are ignored.
  - Each cycle with slot_free: out_vec <= idx, out_f <= tt[idx], out_valid <= 1, cnt <= cnt + tt[idx].
  - If idx == TT_W-1, go to DONE; otherwise idx <= idx + 1 (no wrap).
- DONE:
  - in_ready = 0.
  - At the first edge with slot_free: ones_count <= cnt, sweep_done <= 1 for one cycle, go to IDLE.
- out_valid clears on out_ready unless a new result is loaded in the same cycle.
- Width rules:
  - cnt and ones_count are N_IN+1 bits, so the all-ones table yields TT_W without overflow.
  - idx is N_IN bits.

## Timing
- Evaluation latency is 1 cycle: a request accepted at edge k gives out_valid/out_f valid after edge k.
- Throughput is 1 result per cycle while out_ready = 1.
- Backpressure: while out_valid && !out_ready, out_vec/out_f/out_valid hold stable; a sweep stalls without skipping an index.
- Sweep with out_ready tied to 1, start sampled at edge 0:
  - pair i appears after edge i+1 (i = 0..TT_W-1);
  - DONE is entered at edge TT_W;
  - sweep_done is high for the cycle after edge TT_W+1;
  - sweep_busy is high from edge 0 to edge TT_W+1.
- Loading a full table takes TT_W load_en cycles; partial loads are legal and shift only the bits given.
- Reset values:
  - tt = INIT, state = IDLE;
  - out_valid/out_f/out_vec = 0;
  - sweep_done = 0, sweep_busy = 0;
  - ones_count = 0, idx = 0, cnt = 0.
- Reset asserted mid-sweep or mid-load aborts immediately: the table returns to INIT and no sweep_done is generated.

## Structure
- Shared package logic_lut_pkg holds:
  - state encodings (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2);
  - the default INIT constant.
- Sub-module tt_shift_reg (parameter TT_W, INIT) holds the truth-table shift register and its read mux.
- FSM, counters and output register stay in the top module.

## Test plan
- Reset, no load, out_ready = 1; request vectors 0..15 in turn -> out_f = 1 exactly for 2, 4, 7, 11, 12; one result per cycle.
- sweep_start with the default table, out_ready = 1 -> 16 pairs in index order; ones_count = 5; sweep_done pulses once at the cycle given in Timing.
- Serially load 16'hFFFF, then sweep -> ones_count = 16 (5'b10000); then load 16'h0000 and sweep -> 0.
- Hold out_ready = 0 for 3 cycles mid-sweep at idx 6 -> out_vec = 6 held stable; no index skipped or repeated; final count unchanged.
- sweep_start together with in_valid in IDLE -> in_ready = 0 and the sweep runs; load_en pulses during SWEEP -> table unchanged.
- Assert rst_n = 0 at idx 9 of a sweep -> all outputs at reset values, no sweep_done; table back to INIT (verified by a follow-up sweep giving 5).
